// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement sequencer.
// No logic; constants and the sequencer state encoding only.
// Consumers import with ro_meas_pkg::*.
package ro_meas_pkg;

  localparam int RO_NUM_RO_DEF     = 4;
  localparam int RO_SEL_W_DEF      = 2;
  localparam int RO_GATE_W_DEF     = 16;
  localparam int RO_CNT_W_DEF      = 16;
  localparam int RO_SETTLE_CYC_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for one asynchronous oscillator output, plus rising-edge pulse.
// Latency: an input edge shows up as rise_o two to three clk edges later.
// No backpressure; the pulse is one cycle wide and is free-running.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ro_i,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  // Metastability chain followed by one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= ro_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Sequences the ring-oscillator bank: enable one RO, settle, count edges over a gate window.
// Latency: start -> res_valid after 1 + SETTLE_CYC + gate_len cycles (gate_len 0 counts as 1).
// Backpressure: result is held in RESULT until res_ready; the scan pauses while held.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO     = RO_NUM_RO_DEF,
  parameter int SEL_W      = RO_SEL_W_DEF,
  parameter int GATE_W     = RO_GATE_W_DEF,
  parameter int CNT_W      = RO_CNT_W_DEF,
  parameter int SETTLE_CYC = RO_SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              scan,
  input  logic [SEL_W-1:0]  sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_data,
  output logic [SEL_W-1:0]  res_id,
  output logic              res_ovf
);

  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_RO - 1);
  localparam logic [GATE_W-1:0] SETTLE_LD = GATE_W'(SETTLE_CYC - 1);

  logic [NUM_RO-1:0] rise;

  genvar g;
  generate
    for (g = 0; g < NUM_RO; g++) begin : g_sync
      ro_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .ro_i   (ro_in[g]),
        .rise_o (rise[g])
      );
    end
  endgenerate

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              scan_q, scan_d;
  logic [GATE_W-1:0] glen_q, glen_d;
  logic [GATE_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [NUM_RO-1:0] en_q, en_d;
  logic              sel_rise;
  logic [SEL_W-1:0]  sel_cl;

  // Out-of-range single-shot selects fall back to the highest oscillator.
  assign sel_cl = (sel > LAST_IDX) ? LAST_IDX : sel;

  // Pick the edge pulse of the oscillator currently being measured.
  always_comb begin
    sel_rise = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (idx_q == SEL_W'(i)) sel_rise = rise[i];
    end
  end

  // Next-state, timers, edge counter and the registered enable for the next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scan_d  = scan_q;
    glen_d  = glen_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    en_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          glen_d  = (gate_len == '0) ? GATE_W'(1) : gate_len;
          scan_d  = scan;
          idx_d   = scan ? '0 : sel_cl;
          tmr_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (tmr_q == '0) begin
          tmr_d   = glen_q - GATE_W'(1);
          state_d = S_GATE;
        end else begin
          tmr_d = tmr_q - GATE_W'(1);
        end
      end
      S_GATE: begin
        if (sel_rise) begin
          if (cnt_q == '1) ovf_d = 1'b1;
          else             cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) state_d = S_RESULT;
        else             tmr_d   = tmr_q - GATE_W'(1);
      end
      S_RESULT: begin
        if (res_ready) begin
          if (scan_q && (idx_q < LAST_IDX)) begin
            idx_d   = idx_q + SEL_W'(1);
            tmr_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Enable is computed from the next state so the flop output tracks the state exactly.
    if ((state_d == S_SETTLE) || (state_d == S_GATE)) begin
      for (int i = 0; i < NUM_RO; i++) begin
        en_d[i] = (idx_d == SEL_W'(i));
      end
    end
  end

  // State and datapath registers; reset drops the enable and any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      scan_q  <= 1'b0;
      glen_q  <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
      glen_q  <= glen_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
    end
  end

  assign ro_en     = en_q;
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESULT);
  assign res_data  = cnt_q;
  assign res_id    = idx_q;
  assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: default 4-RO instance plus a 3-RO / 4-bit-counter instance.
// Oscillators are modelled as square waves toggled on the falling clock edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_ro_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Default instance
  logic        start = 1'b0, scan = 1'b0, res_ready = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] gate_len = 16'd0;
  logic [3:0]  ro_in = 4'b0;
  logic [3:0]  ro_en;
  logic        busy, res_valid, res_ovf;
  logic [15:0] res_data;
  logic [1:0]  res_id;

  // Small instance: NUM_RO=3, CNT_W=4
  logic        start2 = 1'b0, scan2 = 1'b0, ready2 = 1'b0;
  logic [1:0]  sel2 = 2'd0;
  logic [15:0] gate2 = 16'd0;
  logic [2:0]  ro2 = 3'b0;
  logic [2:0]  ro_en2;
  logic        busy2, valid2, ovf2;
  logic [3:0]  data2;
  logic [1:0]  id2;

  int n_chk  = 0;
  int n_pass = 0;

  int half[4] = '{4, 6, 8, 10};
  int rc[4]   = '{0, 0, 0, 0};
  int c2      = 0;

  ro_meas_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .scan(scan), .sel(sel), .gate_len(gate_len),
    .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf)
  );

  ro_meas_ctrl #(.NUM_RO(3), .SEL_W(2), .GATE_W(16), .CNT_W(4), .SETTLE_CYC(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .scan(scan2), .sel(sel2), .gate_len(gate2),
    .ro_in(ro2), .ro_en(ro_en2), .busy(busy2), .res_valid(valid2), .res_ready(ready2),
    .res_data(data2), .res_id(id2), .res_ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Oscillator models: each RO toggles every half[i] clocks.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rc[i] >= half[i] - 1) begin
        rc[i]    <= 0;
        ro_in[i] <= ~ro_in[i];
      end else begin
        rc[i] <= rc[i] + 1;
      end
    end
    if (c2 >= 1) begin
      c2     <= 0;
      ro2[2] <= ~ro2[2];
    end else begin
      c2 <= c2 + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    n_chk++;
    assert ((obs >= lo) && (obs <= hi)) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, want %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Step until res_valid, counting edges; checks ro_en each busy cycle (exact if exp_en != 0, else <=1 hot).
  task automatic wait_valid(input int lim, input logic [3:0] exp_en, output int k, output bit bad);
    k   = 0;
    bad = 1'b0;
    while (!res_valid && k < lim) begin
      if (exp_en != 4'b0) begin
        if (ro_en !== exp_en) bad = 1'b1;
      end else begin
        if ($countones(ro_en) > 1) bad = 1'b1;
      end
      step();
      k++;
    end
  endtask

  int          k;
  bit          bad;
  bit          stable;
  logic [15:0] held;
  int          exp_scan[4] = '{30, 20, 15, 12};

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_ovf", res_ovf, 0);
    chk("rst_valid2", valid2, 0);
    rst = 1'b0;
    step();

    // Single shot, RO1 period 8, gate 64; inputs changed after start must not matter
    half[1]   = 4;
    sel       = 2'd1;
    scan      = 1'b0;
    gate_len  = 16'd64;
    res_ready = 1'b1;
    start     = 1'b1;
    step();
    start    = 1'b0;
    sel      = 2'd0;
    gate_len = 16'd5;
    chk("t1_en_settle", ro_en, 4'b0010);
    wait_valid(200, 4'b0010, k, bad);
    chk("t1_latency", k, 72);
    chk("t1_en_held", bad, 0);
    chk_rng("t1_data", res_data, 7, 9);
    chk("t1_id", res_id, 1);
    chk("t1_ovf", res_ovf, 0);
    step();
    chk("t1_valid_drop", res_valid, 0);
    chk("t1_busy_end", busy, 0);

    // Scan with res_ready high: four back-to-back results
    half     = '{4, 6, 8, 10};
    gate_len = 16'd240;
    scan     = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    scan  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_valid(400, 4'b0, k, bad);
      chk("t2_latency", k, 248);
      chk("t2_onehot", bad, 0);
      chk("t2_id", res_id, r);
      chk_rng("t2_data", res_data, exp_scan[r] - 1, exp_scan[r] + 1);
      step();
    end
    chk("t2_busy_end", busy, 0);
    chk("t2_valid_end", res_valid, 0);

    // Stalled result: held stable, enables off, start during stall ignored
    sel       = 2'd2;
    gate_len  = 16'd64;
    res_ready = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_valid(200, 4'b0100, k, bad);
    chk("t4_latency", k, 72);
    chk("t4_en_held", bad, 0);
    chk_rng("t4_data", res_data, 3, 5);
    chk("t4_id", res_id, 2);
    held   = res_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_data !== held || res_id !== 2'd2 || ro_en !== 4'b0) stable = 1'b0;
      start = (i == 4);
      scan  = (i == 4);
      step();
    end
    start = 1'b0;
    scan  = 1'b0;
    chk("t4_stable", stable, 1);
    res_ready = 1'b1;
    step();
    chk("t4_valid_drop", res_valid, 0);
    chk("t4_start_ignored", busy, 0);

    // gate_len 0 behaves as 1
    sel      = 2'd0;
    gate_len = 16'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_valid(50, 4'b0001, k, bad);
    chk("t5_latency", k, 9);
    step();

    // Small instance: sel 3 clamps to 2, period 4 over 200 cycles saturates 4-bit counter
    sel2   = 2'd3;
    gate2  = 16'd200;
    ready2 = 1'b1;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("t3_en", ro_en2, 3'b100);
    k   = 0;
    bad = 1'b0;
    while (!valid2 && k < 400) begin
      if (ro_en2 !== 3'b100) bad = 1'b1;
      step();
      k++;
    end
    chk("t3_latency", k, 208);
    chk("t3_en_held", bad, 0);
    chk("t3_data", data2, 4'hF);
    chk("t3_ovf", ovf2, 1);
    chk("t5_clamp_id", id2, 2);
    step();
    chk("t3_busy_end", busy2, 0);

    // Reset mid-GATE, then a fresh measurement
    sel      = 2'd0;
    gate_len = 16'd64;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("t6_busy_gate", busy, 1);
    rst = 1'b1;
    step();
    chk("t6_ro_en", ro_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_valid", res_valid, 0);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(200, 4'b0001, k, bad);
    chk("t6_latency", k, 72);
    chk_rng("t6_data", res_data, 7, 9);
    chk("t6_id", res_id, 0);
    chk("t6_ovf", res_ovf, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
